aie_ring_noc: RTL and testbench

AIE_RING_NOC -- requirements
Module: aie_ring_noc

---
 rtl/aie_noc_pkg.sv | 29 ++
 rtl/aie_ring_noc_if.sv | 31 +++
 rtl/aie_ring_station.sv | 112 +++++++++++
 rtl/aie_ring_noc.sv | 62 ++++++
 tb/tb_aie_ring_noc.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aie_noc_pkg.sv
// Shared constants and helpers for the AIE ring NoC: default parameters,
// id width and the {src, dest, data} flit layout.
package aie_noc_pkg;

  localparam int NUM_TILES_DEF    = 4;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int FIFO_DEPTH_DEF   = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  // Flit layout, LSB first: data, then dest, then src.
  localparam int DATA_LSB = 0;

  function automatic int idw_f(input int num_tiles);
    return (num_tiles <= 2) ? 1 : $clog2(num_tiles);
  endfunction

  function automatic int dest_lsb(input int data_width);
    return DATA_LSB + data_width;
  endfunction

  function automatic int src_lsb(input int data_width, input int idw);
    return DATA_LSB + data_width + idw;
  endfunction

  function automatic int flit_w(input int data_width, input int idw);
    return data_width + 2 * idw;
  endfunction

endpackage

// File: rtl/aie_ring_noc_if.sv
// Local inject/eject ports of every ring station, bundled as one interface.
interface aie_ring_noc_if
  import aie_noc_pkg::*;
#(
  parameter int NUM_TILES  = NUM_TILES_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  localparam int IDW = idw_f(NUM_TILES);

  // Per-station valid/ready: a transfer happens on the rising edge where
  // valid && ready; the producer holds valid and payload stable until then.
  logic [NUM_TILES-1:0]            inj_valid;
  logic [NUM_TILES-1:0]            inj_ready;
  logic [NUM_TILES*DATA_WIDTH-1:0] inj_data;
  logic [NUM_TILES*IDW-1:0]        inj_dest;
  logic [NUM_TILES-1:0]            ej_valid;
  logic [NUM_TILES-1:0]            ej_ready;
  logic [NUM_TILES*DATA_WIDTH-1:0] ej_data;
  logic [NUM_TILES*IDW-1:0]        ej_src;

  modport master (
    output inj_valid, inj_data, inj_dest, ej_ready,
    input  inj_ready, ej_valid, ej_data, ej_src
  );

  modport slave (
    input  inj_valid, inj_data, inj_dest, ej_ready,
    output inj_ready, ej_valid, ej_data, ej_src
  );

endinterface

// File: rtl/aie_ring_station.sv
// One ring stop: show-ahead ring FIFO, output link register, eject port and
// inject arbitration with a starvation override.
module aie_ring_station
  import aie_noc_pkg::*;
#(
  parameter int ID           = 0,
  parameter int NUM_TILES    = NUM_TILES_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int IDW = idw_f(NUM_TILES),
  localparam int FW  = flit_w(DATA_WIDTH, IDW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [FW-1:0]         in_flit,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [FW-1:0]         out_flit,
  input  logic                  out_ready,
  input  logic                  inj_valid,
  output logic                  inj_ready,
  input  logic [DATA_WIDTH-1:0] inj_data,
  input  logic [IDW-1:0]        inj_dest,
  output logic                  ej_valid,
  input  logic                  ej_ready,
  output logic [DATA_WIDTH-1:0] ej_data,
  output logic [IDW-1:0]        ej_src,
  output logic                  bad_accept
);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int DEST_LSB = dest_lsb(DATA_WIDTH);
  localparam int SRC_LSB  = src_lsb(DATA_WIDTH, IDW);
  localparam logic [IDW-1:0] MY_ID   = IDW'(ID);
  localparam logic [IDW:0]   NT      = (IDW + 1)'(NUM_TILES);
  localparam logic [AW:0]    DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]  LIMIT   = CW'(STARVE_LIMIT);

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve_cnt;
  logic [FW-1:0] head;
  logic fifo_empty, fifo_full, fwd_cand, reg_free, force_inj, dest_bad;
  logic inj_win, fwd_move, push, pop;

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;

  assign ej_valid = !fifo_empty && (head[DEST_LSB +: IDW] == MY_ID);
  assign ej_data  = head[DATA_LSB +: DATA_WIDTH];
  assign ej_src   = head[SRC_LSB +: IDW];
  assign fwd_cand = !fifo_empty && (head[DEST_LSB +: IDW] != MY_ID);

  // Transit traffic normally wins the output register; a starved injector
  // takes it once, leaving the transit head in the FIFO for the next cycle.
  assign reg_free   = !out_valid || out_ready;
  assign force_inj  = (starve_cnt == LIMIT);
  assign dest_bad   = ({1'b0, inj_dest} >= NT);
  assign inj_ready  = rst_n && (dest_bad || (reg_free && (!fwd_cand || force_inj)));
  assign inj_win    = inj_valid && inj_ready && !dest_bad;
  assign fwd_move   = fwd_cand && reg_free && !inj_win;
  assign pop        = (ej_valid && ej_ready) || fwd_move;
  assign bad_accept = inj_valid && inj_ready && dest_bad;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else if (inj_win) begin
      out_valid <= 1'b1;
      out_flit  <= {MY_ID, inj_dest, inj_data};
    end else if (fwd_move) begin
      out_valid <= 1'b1;
      out_flit  <= head;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!inj_valid || inj_ready) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/aie_ring_noc.sv
// Unidirectional ring of NUM_TILES stations; station i forwards to i+1 mod N.
// err_bad_dest latches any accepted inject addressed outside the ring.
module aie_ring_noc
  import aie_noc_pkg::*;
#(
  parameter int NUM_TILES    = NUM_TILES_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  aie_ring_noc_if.slave bus,
  output logic          err_bad_dest
);
  localparam int IDW = idw_f(NUM_TILES);
  localparam int FW  = flit_w(DATA_WIDTH, IDW);

  logic [NUM_TILES-1:0]            link_valid, link_ready, bad_accept;
  logic [FW-1:0]                   link_flit [NUM_TILES];
  logic [NUM_TILES-1:0]            inj_ready, ej_valid;
  logic [NUM_TILES*DATA_WIDTH-1:0] ej_data;
  logic [NUM_TILES*IDW-1:0]        ej_src;

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_st
    // link i runs from station i's output register into station i+1's FIFO
    localparam int UP = (i + NUM_TILES - 1) % NUM_TILES;
    aie_ring_station #(
      .ID(i), .NUM_TILES(NUM_TILES), .DATA_WIDTH(DATA_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) u_st (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (link_valid[UP]),
      .in_flit   (link_flit[UP]),
      .in_ready  (link_ready[UP]),
      .out_valid (link_valid[i]),
      .out_flit  (link_flit[i]),
      .out_ready (link_ready[i]),
      .inj_valid (bus.inj_valid[i]),
      .inj_ready (inj_ready[i]),
      .inj_data  (bus.inj_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .inj_dest  (bus.inj_dest[i*IDW +: IDW]),
      .ej_valid  (ej_valid[i]),
      .ej_ready  (bus.ej_ready[i]),
      .ej_data   (ej_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .ej_src    (ej_src[i*IDW +: IDW]),
      .bad_accept(bad_accept[i])
    );
  end

  assign bus.inj_ready = inj_ready;
  assign bus.ej_valid  = ej_valid;
  assign bus.ej_data   = ej_data;
  assign bus.ej_src    = ej_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_bad_dest <= 1'b0;
    else if (|bad_accept) err_bad_dest <= 1'b1;
  end

endmodule

// File: tb/tb_aie_ring_noc.sv
// Directed bench for aie_ring_noc: a 4-station ring for latency, backpressure,
// starvation and reset, plus a 5-station ring for out-of-range destinations.
module tb_aie_ring_noc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err4, err5;
  int   total = 0;
  int   bad = 0;
  logic [11:0] exp_q[$];   // {eject station, src, data}
  logic [11:0] got_m;
  int   idx_m;

  aie_ring_noc_if #(.NUM_TILES(4), .DATA_WIDTH(8)) bus4 ();
  aie_ring_noc_if #(.NUM_TILES(5), .DATA_WIDTH(8)) bus5 ();

  aie_ring_noc #(.NUM_TILES(4), .DATA_WIDTH(8), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .err_bad_dest(err4)
  );

  aie_ring_noc #(.NUM_TILES(5), .DATA_WIDTH(8), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .err_bad_dest(err5)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: each eject must match the oldest expected flit for that station
  always @(negedge clk) begin
    for (int s = 0; s < 4; s++) begin
      if (rst_n && bus4.ej_valid[s] && bus4.ej_ready[s]) begin
        got_m = {s[1:0], bus4.ej_src[s*2 +: 2], bus4.ej_data[s*8 +: 8]};
        idx_m = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (idx_m < 0 && exp_q[j][11:10] == s[1:0]) idx_m = j;
        total++;
        if (idx_m < 0) begin
          bad++;
          $error("FAIL sb_unexpected observed=%0h expected=none", got_m);
        end else begin
          assert (got_m === exp_q[idx_m]) else begin
            bad++;
            $error("FAIL sb_eject observed=%0h expected=%0h", got_m, exp_q[idx_m]);
          end
          exp_q.delete(idx_m);
        end
      end
    end
  end

  // driver: one inject on an idle ring, then time the eject valid
  task automatic send_and_time(input int src, input int dest, input logic [7:0] data,
                               input int exp_lat, input string tag);
    int lat;
    lat = 0;
    bus4.inj_valid[src]         = 1'b1;
    bus4.inj_data[src*8 +: 8]   = data;
    bus4.inj_dest[src*2 +: 2]   = dest[1:0];
    exp_q.push_back({dest[1:0], src[1:0], data});
    @(negedge clk);
    check({tag, "_inj_ready"}, 32'(bus4.inj_ready[src]), 32'd1);
    tick();
    bus4.inj_valid[src] = 1'b0;
    for (int k = 1; k <= exp_lat + 4 && lat == 0; k++) begin
      @(negedge clk);
      if (bus4.ej_valid[dest]) begin
        lat = k;
        check({tag, "_ej_data"}, 32'(bus4.ej_data[dest*8 +: 8]), 32'(data));
        check({tag, "_ej_src"}, 32'(bus4.ej_src[dest*2 +: 2]), 32'(src));
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    repeat (3) tick();
  endtask

  initial begin
    int n, tot, k0, acc0, lat_a, lat_b;
    logic [4:0] ej_seen;

    bus4.inj_valid = '0; bus4.inj_data = '0; bus4.inj_dest = '0; bus4.ej_ready = 4'hF;
    bus5.inj_valid = '0; bus5.inj_data = '0; bus5.inj_dest = '0; bus5.ej_ready = 5'h1F;

    // reset
    repeat (2) @(negedge clk);
    check("rst_ej_valid", 32'(bus4.ej_valid), 32'd0);
    check("rst_inj_ready", 32'(bus4.inj_ready), 32'd0);
    check("rst_err", 32'(err4), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_inj_ready", 32'(bus4.inj_ready), 32'hF);
    check("idle_ej_valid", 32'(bus4.ej_valid), 32'd0);
    tick();

    // idle-ring latency: 2 cycles per hop
    send_and_time(0, 2, 8'hA5, 4, "hop2");
    send_and_time(1, 1, 8'h5A, 8, "self_loop");
    send_and_time(3, 0, 8'h11, 2, "wrap_hop1");

    // backpressure: station 3 refuses ejects while station 2 streams to it
    bus4.ej_ready[3] = 1'b0;
    n = 0;
    bus4.inj_valid[2] = 1'b1; bus4.inj_dest[5:4] = 2'd3; bus4.inj_data[23:16] = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus4.inj_valid[2] && bus4.inj_ready[2]) begin
        exp_q.push_back({2'd3, 2'd2, n[7:0]});
        n++;
      end
      tick();
      bus4.inj_data[23:16] = n[7:0];
      bus4.inj_valid[2] = (n < 10);
    end
    check("bp_accepted", 32'(n), 32'd5);
    @(negedge clk);
    check("bp_inj_stall", 32'(bus4.inj_ready[2]), 32'd0);
    check("bp_ej_valid", 32'(bus4.ej_valid[3]), 32'd1);
    check("bp_ej_hold", 32'(bus4.ej_data[31:24]), 32'h00);
    tick();
    bus4.ej_ready[3] = 1'b1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (bus4.inj_valid[2] && bus4.inj_ready[2]) begin
        exp_q.push_back({2'd3, 2'd2, n[7:0]});
        n++;
      end
      tick();
      bus4.inj_data[23:16] = n[7:0];
      bus4.inj_valid[2] = (n < 10);
    end
    bus4.inj_valid[2] = 1'b0;
    check("bp_total", 32'(n), 32'd10);
    repeat (15) tick();
    check("bp_drain", 32'(exp_q.size()), 32'd0);

    // starvation: station 3 floods station 1 through station 0
    n = 0; k0 = 0; acc0 = 0; lat_a = 0; lat_b = 0;
    bus4.inj_valid[3] = 1'b1; bus4.inj_dest[7:6] = 2'd1; bus4.inj_data[31:24] = 8'h40;
    for (int c = 0; c < 80 && n < 30; c++) begin
      if (c == 4) begin
        bus4.inj_valid[0] = 1'b1; bus4.inj_dest[1:0] = 2'd2; bus4.inj_data[7:0] = 8'h77;
      end
      @(negedge clk);
      if (bus4.inj_valid[0]) begin
        k0++;
        if (bus4.inj_ready[0]) begin
          exp_q.push_back({2'd2, 2'd0, bus4.inj_data[7:0]});
          if (acc0 == 0) lat_a = k0;
          else lat_b = k0;
          acc0++;
          k0 = 0;
        end
      end
      if (bus4.inj_ready[3]) begin
        exp_q.push_back({2'd1, 2'd3, bus4.inj_data[31:24]});
        n++;
      end
      tick();
      bus4.inj_data[31:24] = 8'h40 + n[7:0];
      if (acc0 == 1) bus4.inj_data[7:0] = 8'h78;
      if (acc0 >= 2) bus4.inj_valid[0] = 1'b0;
    end
    bus4.inj_valid[3] = 1'b0;
    bus4.inj_valid[0] = 1'b0;
    check("starve_first", 32'(lat_a), 32'd9);
    check("starve_second", 32'(lat_b), 32'd9);
    check("starve_stream", 32'(n), 32'd30);
    repeat (20) tick();
    check("starve_drain", 32'(exp_q.size()), 32'd0);

    // out-of-range destination on the 5-station ring
    bus5.inj_valid[0] = 1'b1; bus5.inj_dest[2:0] = 3'd5; bus5.inj_data[7:0] = 8'h99;
    @(negedge clk);
    check("bad_inj_ready", 32'(bus5.inj_ready[0]), 32'd1);
    check("bad_err_before", 32'(err5), 32'd0);
    tick();
    bus5.inj_valid[0] = 1'b0;
    ej_seen = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ej_seen = ej_seen | bus5.ej_valid;
      tick();
    end
    check("bad_no_eject", 32'(ej_seen), 32'd0);
    check("bad_err_sticky", 32'(err5), 32'd1);
    check("good_ring_err", 32'(err4), 32'd0);

    // reset with flits in flight
    bus4.ej_ready[3] = 1'b0;
    tot = 0;
    for (int s = 0; s < 3; s++) begin
      bus4.inj_valid[s] = 1'b1;
      bus4.inj_dest[s*2 +: 2] = 2'd3;
      bus4.inj_data[s*8 +: 8] = 8'hE0 + 8'(s);
    end
    for (int c = 0; c < 20 && tot < 6; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++)
        if (bus4.inj_valid[s] && bus4.inj_ready[s]) tot++;
      tick();
    end
    bus4.inj_valid = '0;
    check("inflight_count", 32'(tot >= 6), 32'd1);
    @(negedge clk);
    check("inflight_ej_valid", 32'(bus4.ej_valid[3]), 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ej_valid", 32'(bus4.ej_valid), 32'd0);
    check("midrst_inj_ready", 32'(bus4.inj_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus4.ej_ready = 4'hF;
    @(negedge clk);
    check("postrst_err5", 32'(err5), 32'd0);
    check("postrst_ej_valid", 32'(bus4.ej_valid), 32'd0);
    tick();
    send_and_time(0, 1, 8'h3C, 2, "post_rst");
    repeat (5) tick();
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
